// File: rtl/ev22_sequencer.sv
// ev22_sequencer: fetch/decode/execute controller for the EV22 core.
//
// Holds the PC, the instruction register and a circular subroutine return
// stack. It runs the instruction- and data-memory handshakes and resolves
// JMP/JZE/JNE/JCY/BSR/RET. It also emits the one-cycle commit strobe that
// gates every datapath write.
//
// Optional feature macro: EV22_SEQ_SINGLE_STEP_EN
//   When defined, the ports step/halted and a HALT state are added. After
//   every commit the sequencer parks in HALT until a step pulse is sampled.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   imem_addr/req/ack/data   instruction fetch handshake (addr = pc)
//   ir_opcode, ir_operand    latched instruction word, to the decoder
//   dec_mr, dec_mw           decoder memory-read / memory-write flags
//   w_zero, w_sign, cy       datapath flags, sampled in the commit cycle
//   dmem_req/we/ack          data-memory handshake
//   commit                   one-cycle datapath write strobe
//   pc                       current program counter
//   stk_err                  sticky return-stack overflow/underflow
//   step, halted             single-step control (macro builds only)
module ev22_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [23:0]       imem_data,
  output logic [7:0]        ir_opcode,
  output logic [15:0]       ir_operand,
  input  logic              dec_mr,
  input  logic              dec_mw,
  input  logic              w_zero,
  input  logic              w_sign,
  input  logic              cy,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              commit,
  output logic [ADDR_W-1:0] pc,
`ifdef EV22_SEQ_SINGLE_STEP_EN
  input  logic              step,
  output logic              halted,
`endif
  output logic              stk_err
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [7:0]        ir_opcode_r;
  logic [15:0]       ir_operand_r;
  logic [ADDR_W-1:0] stk_r [STACK_DEPTH];
  logic [SP_W-1:0]   top_r;   // slot the next push writes
  logic [SP_W:0]     cnt_r;   // number of live entries, 0..STACK_DEPTH
  logic              stk_err_r;

  logic              mem_op_s;
  logic              exec_done_s;
  logic              commit_s;
  logic              is_jmp_s;
  logic              is_jze_s;
  logic              is_jne_s;
  logic              is_jcy_s;
  logic              is_bsr_s;
  logic              is_ret_s;
  logic              stk_empty_s;
  logic              stk_full_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] ret_val_s;
  logic              imem_req_s;
  logic              dmem_req_s;
  logic              dmem_we_s;
  logic              halted_s;

  // Opcode classes and the operands used by the PC update.
  assign is_jmp_s    = (ir_opcode_r[7:3] == 5'b00100);
  assign is_jze_s    = (ir_opcode_r[7:3] == 5'b00101);
  assign is_jne_s    = (ir_opcode_r[7:3] == 5'b00110);
  assign is_jcy_s    = (ir_opcode_r[7:3] == 5'b00111);
  assign is_bsr_s    = (ir_opcode_r[7:2] == 6'b000111);
  assign is_ret_s    = (ir_opcode_r == 8'h41);
  assign mem_op_s    = dec_mr | dec_mw;
  assign stk_empty_s = (cnt_r == '0);
  assign stk_full_s  = (cnt_r == (SP_W+1)'(STACK_DEPTH));
  assign pc_inc_s    = pc_r + ADDR_W'(1);
  assign target_s    = ir_operand_r[ADDR_W-1:0];
  assign ret_val_s   = stk_r[top_r - SP_W'(1)] + ADDR_W'(1);

  // The instruction retires in EXEC once any data-memory access has completed.
  assign exec_done_s = (state_r == ST_EXEC) && (!mem_op_s || dmem_ack);
  assign commit_s    = exec_done_s && !reset;

  // Next PC. Adding the low operand bits at full PC width is the same as
  // adding the sign-extended branch offset, modulo 2^ADDR_W.
  always_comb begin
    pc_next_s = pc_inc_s;
    if (is_jmp_s) begin
      pc_next_s = target_s;
    end else if ((is_jze_s && w_zero) || (is_jne_s && !w_sign) || (is_jcy_s && cy)) begin
      pc_next_s = target_s;
    end else if (is_bsr_s) begin
      pc_next_s = pc_r + target_s;
    end else if (is_ret_s && !stk_empty_s) begin
      pc_next_s = ret_val_s;
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH:  state_s = imem_ack ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_s = ST_EXEC;
`ifdef EV22_SEQ_SINGLE_STEP_EN
      ST_EXEC:   state_s = exec_done_s ? ST_HALT : ST_EXEC;
      ST_HALT:   state_s = step ? ST_FETCH : ST_HALT;
`else
      ST_EXEC:   state_s = exec_done_s ? ST_FETCH : ST_EXEC;
`endif
      default:   state_s = ST_FETCH;
    endcase
  end

  // FSM outputs. Reset forces every handshake output low, so a request
  // in flight is withdrawn while reset is held.
  always_comb begin
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    halted_s   = 1'b0;
    if (!reset) begin
      case (state_r)
        ST_FETCH: imem_req_s = 1'b1;
        ST_EXEC: begin
          dmem_req_s = mem_op_s;
          dmem_we_s  = mem_op_s & dec_mw;
        end
        ST_HALT:  halted_s = 1'b1;
        default:  imem_req_s = 1'b0;
      endcase
    end else begin
      imem_req_s = 1'b0;
    end
  end

  // PC, instruction register, stack pointer and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= ADDR_W'(RESET_PC);
      ir_opcode_r  <= 8'h00;
      ir_operand_r <= 16'h0000;
      top_r        <= '0;
      cnt_r        <= '0;
      stk_err_r    <= 1'b0;
    end else begin
      if ((state_r == ST_FETCH) && imem_ack) begin
        ir_opcode_r  <= imem_data[23:16];
        ir_operand_r <= imem_data[15:0];
      end
      if (commit_s) begin
        pc_r <= pc_next_s;
        if (is_bsr_s) begin
          // A full stack keeps its count and loses its oldest entry.
          top_r <= top_r + SP_W'(1);
          if (stk_full_s) begin
            stk_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + (SP_W+1)'(1);
          end
        end else if (is_ret_s) begin
          if (stk_empty_s) begin
            stk_err_r <= 1'b1;
          end else begin
            top_r <= top_r - SP_W'(1);
            cnt_r <= cnt_r - (SP_W+1)'(1);
          end
        end
      end
    end
  end

  // Return-stack storage. Contents are only read when the count covers them,
  // so the entries need no reset.
  always_ff @(posedge clk) begin
    if (commit_s && is_bsr_s) begin
      stk_r[top_r] <= pc_r;
    end
  end

  assign imem_addr  = pc_r;
  assign imem_req   = imem_req_s;
  assign ir_opcode  = ir_opcode_r;
  assign ir_operand = ir_operand_r;
  assign dmem_req   = dmem_req_s;
  assign dmem_we    = dmem_we_s;
  assign commit     = commit_s;
  assign pc         = pc_r;
  assign stk_err    = stk_err_r;
`ifdef EV22_SEQ_SINGLE_STEP_EN
  assign halted     = halted_s;
`endif

endmodule

// File: tb/tb_ev22_sequencer.sv
`timescale 1ns/1ps
module tb_ev22_sequencer;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;
`ifdef EV22_SEQ_SINGLE_STEP_EN
  localparam int GAP_BASE = 4;
`else
  localparam int GAP_BASE = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_ack;
  logic [23:0]   imem_data;
  logic [7:0]    ir_opcode;
  logic [15:0]   ir_operand;
  logic          dec_mr, dec_mw, w_zero, w_sign, cy;
  logic          dmem_req, dmem_we, dmem_ack;
  logic          commit;
  logic [AW-1:0] pc;
  logic          stk_err;
`ifdef EV22_SEQ_SINGLE_STEP_EN
  logic          step = 1'b0;
  logic          halted;
`endif

  always #5 clk = ~clk;

  ev22_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand),
    .dec_mr(dec_mr), .dec_mw(dec_mw), .w_zero(w_zero), .w_sign(w_sign), .cy(cy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .commit(commit), .pc(pc),
`ifdef EV22_SEQ_SINGLE_STEP_EN
    .step(step), .halted(halted),
`endif
    .stk_err(stk_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  op;
    logic [15:0] opd;
    bit          mem;
    bit          we;
    int          npc;
    bit          err;
    int          gap;
    bit          gap_ok;
  } exp_t;

  exp_t q[$];
  int   mpc;
  int   mstk[$];
  bit   merr;
  bit   first_instr;

  // Architectural effect of one instruction on pc / stack / error flag.
  task automatic model_step(input logic [7:0] op, input logic [15:0] opd,
                            input bit wz, input bit ws, input bit c, output int npc);
    int tgt;
    int off;
    tgt = opd & MASK;
    off = opd & MASK;
    if (off >= (1 << (AW - 1))) off = off - (1 << AW);
    npc = (mpc + 1) % (1 << AW);
    if (op >= 8'h20 && op <= 8'h27) npc = tgt;
    else if (op >= 8'h28 && op <= 8'h2F) begin if (wz) npc = tgt; end
    else if (op >= 8'h30 && op <= 8'h37) begin if (!ws) npc = tgt; end
    else if (op >= 8'h38 && op <= 8'h3F) begin if (c) npc = tgt; end
    else if (op >= 8'h1C && op <= 8'h1F) begin
      mstk.push_back(mpc);
      if (mstk.size() > DEPTH) begin
        void'(mstk.pop_front());
        merr = 1'b1;
      end
      npc = (mpc + off + (1 << AW)) % (1 << AW);
    end else if (op == 8'h41) begin
      if (mstk.size() == 0) merr = 1'b1;
      else npc = (mstk.pop_back() + 1) % (1 << AW);
    end
    mpc = npc;
  endtask

  function automatic bit is_flow(input logic [7:0] op);
    return (op >= 8'h1C && op <= 8'h3F) || (op == 8'h41);
  endfunction

  // ---------------- driver ----------------
  task automatic run_instr(input logic [7:0] op, input logic [15:0] opd,
                           input bit mr, input bit mw, input bit wz, input bit ws, input bit c,
                           input int iwait, input int dwait);
    int   n;
    int   npc;
    exp_t e;
    n = 0;
    while (!imem_req && n < 40) begin
`ifdef EV22_SEQ_SINGLE_STEP_EN
      step = halted;
`endif
      @(posedge clk); #1;
      n++;
    end
`ifdef EV22_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    check("fetch_req", imem_req, 1'b1);
    if (!imem_req) return;
    check("fetch_addr", imem_addr, mpc);
    repeat (iwait) begin
      dmem_ack = 1'($urandom % 2);   // stray data ack, must be ignored
      @(posedge clk); #1;
      check("req_held", imem_req, 1'b1);
    end
    dmem_ack  = 1'b0;
    imem_ack  = 1'b1;
    imem_data = {op, opd};
    model_step(op, opd, wz, ws, c, npc);
    e.op = op; e.opd = opd; e.mem = mr | mw; e.we = mw;
    e.npc = npc; e.err = merr;
    e.gap = GAP_BASE + iwait + ((mr | mw) ? dwait : 0);
    e.gap_ok = !first_instr;
    first_instr = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    imem_ack  = 1'b0;
    imem_data = 24'($urandom);
    check("req_drop", imem_req, 1'b0);
    dec_mr = mr; dec_mw = mw; w_zero = wz; w_sign = ws; cy = c;
    @(posedge clk); #1;
    if (mr || mw) begin
      for (int k = 0; k < dwait; k++) begin
        check("dmem_req_held", dmem_req, 1'b1);
        check("dmem_we", dmem_we, mw);
        check("no_early_commit", commit, 1'b0);
        imem_ack = 1'($urandom % 2);  // stray fetch ack, must be ignored
        @(posedge clk); #1;
      end
      imem_ack = 1'b0;
      check("dmem_req_last", dmem_req, 1'b1);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    dec_mr = 1'b0; dec_mw = 1'b0;
  endtask

  task automatic do_reset(input bit late_ack);
    // Let the previous instruction retire and leave a fetch request pending.
    repeat (2) begin
`ifdef EV22_SEQ_SINGLE_STEP_EN
      step = halted;
`endif
      @(posedge clk); #1;
    end
`ifdef EV22_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    if (late_ack) check("pending_req", imem_req, 1'b1);
    reset = 1'b1;
    imem_ack = late_ack; dmem_ack = late_ack; imem_data = 24'h3F_0123;
    dec_mr = 1'b0; dec_mw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_dmem_req", {dmem_req, dmem_we}, 2'b00);
      check("rst_commit", commit, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    mpc = 0; mstk.delete(); merr = 1'b0; q.delete(); first_instr = 1'b1;
    check("rst_pc", pc, 0);
    check("rst_stk_err", stk_err, 1'b0);
    check("rst_ir", {ir_opcode, ir_operand}, 24'h0);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   pend = 1'b0;
  int   pend_pc;
  bit   pend_err;
  int   last_commit = 0;
  exp_t me;

  always @(negedge clk) begin
    if (pend) begin
      check("pc", pc, pend_pc);
      check("stk_err", stk_err, pend_err);
`ifdef EV22_SEQ_SINGLE_STEP_EN
      check("halted", halted, 1'b1);
`endif
      pend = 1'b0;
    end
    if (commit) begin
      if (q.size() == 0) begin
        check("spurious_commit", commit, 1'b0);
      end else begin
        me = q.pop_front();
        check("ir_opcode", ir_opcode, me.op);
        check("ir_operand", ir_operand, me.opd);
        check("commit_dmem_req", dmem_req, me.mem);
        check("commit_dmem_we", dmem_we, me.we);
        if (me.gap_ok) check("commit_gap", cyc - last_commit, me.gap);
        last_commit = cyc;
        pend_pc  = me.npc;
        pend_err = me.err;
        pend     = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0]  rop;
  logic [15:0] ropd;
  bit          rmr, rmw;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 24'h0; dmem_ack = 1'b0;
    dec_mr = 1'b0; dec_mw = 1'b0; w_zero = 1'b0; w_sign = 1'b0; cy = 1'b0;
    first_instr = 1'b1;
    do_reset(1'b0);

    // NOP stream, zero-wait acks: pc 0,1,2 -> 3, commits 3 cycles apart
    repeat (3) run_instr(8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    // conditional branches
    run_instr(8'h28, 16'h0055, 0, 0, 1, 0, 0, 0, 0);   // JZE taken -> 0x055
    run_instr(8'h20, 16'h0007, 0, 0, 0, 0, 0, 1, 0);   // JMP 7
    run_instr(8'h28, 16'h0055, 0, 0, 0, 0, 0, 0, 0);   // JZE not taken -> 8
    run_instr(8'h33, 16'h0100, 0, 0, 0, 1, 0, 0, 0);   // JNE, sign set -> 9
    run_instr(8'h31, 16'h0100, 0, 0, 0, 0, 0, 0, 0);   // JNE taken -> 0x100
    run_instr(8'h3A, 16'h0200, 0, 0, 0, 0, 1, 2, 0);   // JCY taken -> 0x200
    run_instr(8'h3F, 16'h0300, 0, 0, 0, 0, 0, 0, 0);   // JCY not taken -> 0x201
    // memory read with 4-cycle request, then a write
    run_instr(8'h05, 16'h1234, 1, 0, 0, 0, 0, 0, 3);
    run_instr(8'h06, 16'h4321, 0, 1, 0, 0, 0, 1, 1);
    // subroutine call/return
    run_instr(8'h20, 16'h0010, 0, 0, 0, 0, 0, 0, 0);   // JMP 0x010
    run_instr(8'h1C, 16'hFFFD, 0, 0, 0, 0, 0, 0, 0);   // BSR -3 -> 0x00D
    run_instr(8'h41, 16'h0000, 0, 0, 0, 0, 0, 0, 0);   // RET -> 0x011
    // PC wrap
    run_instr(8'h20, 16'h03FF, 0, 0, 0, 0, 0, 0, 0);
    run_instr(8'h77, 16'h0000, 0, 0, 0, 0, 0, 0, 0);   // undefined -> 0
    // RET on empty stack
    run_instr(8'h20, 16'h0020, 0, 0, 0, 0, 0, 0, 0);
    run_instr(8'h41, 16'h0000, 0, 0, 0, 0, 0, 0, 0);   // -> 0x021, stk_err
    // reset during a pending fetch with a late ack
    do_reset(1'b1);
    // five nested BSRs overflow a depth-4 stack, then unwind past empty
    repeat (5) run_instr(8'h1D, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) run_instr(8'h41, 16'h0000, 0, 0, 0, 0, 0, 1, 0);

    // randomized phase
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      rmr = 1'b0; rmw = 1'b0;
      ropd = 16'($urandom);
      case ($urandom % 8)
        0: rop = {5'b00100, 3'($urandom)};
        1: rop = {5'b00101, 3'($urandom)};
        2: rop = {5'b00110, 3'($urandom)};
        3: rop = {5'b00111, 3'($urandom)};
        4: begin rop = {6'b000111, 2'($urandom)}; ropd = 16'($urandom_range(0, 8)) - 16'd4; end
        5: rop = 8'h41;
        default: begin
          rop = 8'($urandom);
          while (is_flow(rop)) rop = 8'($urandom);
          if ($urandom % 2 == 1) begin rmw = 1'($urandom); rmr = !rmw; end
        end
      endcase
      run_instr(rop, ropd, rmr, rmw, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
